exa_crosb_output_arbiter_vc: RTL and testbench



---
 rtl/exa_crosb_output_arbiter_vc.sv | 185 ++++++++++++++++++
 tb/tb_exa_crosb_output_arbiter_vc.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/exa_crosb_output_arbiter_vc.sv
// rtl/exa_crosb_output_arbiter_vc.sv - per-output VC/priority packet arbiter for the exa crossbar
module exa_crosb_output_arbiter_vc #(
    parameter int input_num  = 4,
    parameter int output_num = 8,
    parameter int vc_num     = 3,
    parameter int prio_num   = 2,
    localparam int C  = vc_num * prio_num,
    localparam int CW = (C > 1) ? $clog2(C) : 1,
    localparam int IW = (input_num > 1) ? $clog2(input_num) : 1
) (
    input  logic                        clk,
    input  logic                        resetn,
    input  logic [input_num-1:0][C-1:0] i_request,
    input  logic [C-1:0][CW-1:0]        i_output_vc,
    input  logic                        i_last,
    output logic [input_num-1:0]        o_grant,
    output logic [IW-1:0]               o_input_sel,
    output logic                        o_cts
);

    localparam int VW = (vc_num > 1) ? $clog2(vc_num) : 1;
    localparam int PW = (prio_num > 1) ? $clog2(prio_num) : 1;

    // output_num only documents the crossbar size this instance belongs to
    if (output_num < 1) begin : g_output_num_check
    end

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [VW-1:0] vc_ptr [prio_num];
    logic [IW-1:0] in_ptr [C];

    logic [C-1:0]          cls_req;
    logic [C-1:0]          eff_valid;
    logic [C-1:0][CW-1:0]  eff_src;
    logic                  any_valid;
    logic [PW-1:0]         win_lvl;
    logic [VW-1:0]         win_vc;
    logic [CW-1:0]         win_eff;
    logic [CW-1:0]         win_cls;
    logic [IW-1:0]         win_in;
    logic [VW-1:0]         vc_ptr_nxt;
    logic [IW-1:0]         in_ptr_nxt;
    logic                  arb_en;
    logic [input_num-1:0]  grant_d;
    logic [IW-1:0]         sel_d;

    // source class c has at least one requesting input
    always_comb begin
        cls_req = '0;
        for (int c = 0; c < C; c++) begin
            for (int i = 0; i < input_num; i++) begin
                cls_req[c] = cls_req[c] | i_request[i][c];
            end
        end
    end

    // fold source classes onto effective classes; scanning downward leaves the lowest source index
    always_comb begin
        eff_valid = '0;
        eff_src   = '0;
        for (int e = 0; e < C; e++) begin
            for (int c = C - 1; c >= 0; c--) begin
                if (cls_req[c] && (int'(i_output_vc[c]) == e)) begin
                    eff_valid[e] = 1'b1;
                    eff_src[e]   = CW'(c);
                end
            end
        end
    end

    // highest priority level holding any eligible request
    always_comb begin
        any_valid = 1'b0;
        win_lvl   = '0;
        for (int p = 0; p < prio_num; p++) begin
            if (|eff_valid[p*vc_num +: vc_num]) begin
                any_valid = 1'b1;
                win_lvl   = PW'(p);
            end
        end
    end

    // round-robin VC within the winning level, starting at that level's pointer
    always_comb begin
        int v;
        v      = 0;
        win_vc = '0;
        for (int k = vc_num - 1; k >= 0; k--) begin
            v = int'(vc_ptr[win_lvl]) + k;
            if (v >= vc_num) begin
                v = v - vc_num;
            end
            if (eff_valid[CW'(int'(win_lvl) * vc_num + v)]) begin
                win_vc = VW'(v);
            end
        end
        win_eff = CW'(int'(win_lvl) * vc_num + int'(win_vc));
        win_cls = eff_src[win_eff];
    end

    // round-robin input within the winning source class
    always_comb begin
        int n;
        n      = 0;
        win_in = '0;
        for (int k = input_num - 1; k >= 0; k--) begin
            n = int'(in_ptr[win_cls]) + k;
            if (n >= input_num) begin
                n = n - input_num;
            end
            if (i_request[IW'(n)][win_cls]) begin
                win_in = IW'(n);
            end
        end
        vc_ptr_nxt = (int'(win_vc) == vc_num - 1) ? '0 : VW'(int'(win_vc) + 1);
        in_ptr_nxt = (int'(win_in) == input_num - 1) ? '0 : IW'(int'(win_in) + 1);
    end

    // state register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // next state: arbitrate when idle or at the last beat of the current packet
    always_comb begin
        arb_en  = (state_q == ST_IDLE) || i_last;
        state_d = state_q;
        if (arb_en) begin
            state_d = any_valid ? ST_BUSY : ST_IDLE;
        end
    end

    // next grant/select: load the winner on an arbitration edge, otherwise hold
    always_comb begin
        grant_d = o_grant;
        sel_d   = o_input_sel;
        if (arb_en) begin
            grant_d = '0;
            if (any_valid) begin
                grant_d[win_in] = 1'b1;
                sel_d           = win_in;
            end
        end
    end

    // registered outputs
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            o_grant     <= '0;
            o_input_sel <= '0;
            o_cts       <= 1'b0;
        end else begin
            o_grant     <= grant_d;
            o_input_sel <= sel_d;
            o_cts       <= (state_d == ST_BUSY);
        end
    end

    // advance only the pointers of the level and class that just won
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int p = 0; p < prio_num; p++) begin
                vc_ptr[p] <= '0;
            end
            for (int c = 0; c < C; c++) begin
                in_ptr[c] <= '0;
            end
        end else if (arb_en && any_valid) begin
            vc_ptr[win_lvl] <= vc_ptr_nxt;
            in_ptr[win_cls] <= in_ptr_nxt;
        end
    end

endmodule

// File: tb/tb_exa_crosb_output_arbiter_vc.sv
// tb/tb_exa_crosb_output_arbiter_vc.sv - self-checking bench for exa_crosb_output_arbiter_vc
module tb_exa_crosb_output_arbiter_vc;

    localparam int NI = 4;
    localparam int NV = 3;
    localparam int NP = 2;
    localparam int NC = NV * NP;

    logic                  clk = 1'b0;
    logic                  resetn;
    logic [NI-1:0][NC-1:0] req;
    logic [NC-1:0][2:0]    vmap;
    logic                  last;
    logic [NI-1:0]         grant;
    logic [1:0]            sel;
    logic                  cts;

    int errors = 0;
    int checks = 0;

    int m_vc_ptr [NP];
    int m_in_ptr [NC];
    bit m_busy;
    int m_grant_in;
    int m_sel;

    always #5 clk = ~clk;

    exa_crosb_output_arbiter_vc #(
        .input_num (NI),
        .output_num(8),
        .vc_num    (NV),
        .prio_num  (NP)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .i_request  (req),
        .i_output_vc(vmap),
        .i_last     (last),
        .o_grant    (grant),
        .o_input_sel(sel),
        .o_cts      (cts)
    );

    function automatic void model_reset();
        for (int p = 0; p < NP; p++) m_vc_ptr[p] = 0;
        for (int c = 0; c < NC; c++) m_in_ptr[c] = 0;
        m_busy     = 0;
        m_grant_in = 0;
        m_sel      = 0;
    endfunction

    function automatic bit class_has_req(int c);
        bit r;
        r = 0;
        for (int i = 0; i < NI; i++) if (req[i][c]) r = 1;
        return r;
    endfunction

    // pick a winner straight from the rules: top level, VC rotation, lowest source, input rotation
    function automatic void model_arb(output bit found, output int wi, output int wc,
                                      output int wl, output int wv);
        bit got;
        found = 0; wi = 0; wc = 0; wl = -1; wv = 0;
        for (int c = 0; c < NC; c++)
            if (class_has_req(c) && vmap[c] < NC && int'(vmap[c]) / NV > wl)
                wl = int'(vmap[c]) / NV;
        if (wl < 0) return;
        found = 1;
        got = 0;
        for (int k = 0; k < NV; k++) begin
            int v, e;
            v = (m_vc_ptr[wl] + k) % NV;
            e = wl * NV + v;
            for (int c = 0; c < NC; c++) begin
                if (!got && int'(vmap[c]) == e && class_has_req(c)) begin
                    got = 1; wc = c; wv = v;
                end
            end
        end
        got = 0;
        for (int k = 0; k < NI; k++) begin
            int i;
            i = (m_in_ptr[wc] + k) % NI;
            if (!got && req[i][wc]) begin
                got = 1; wi = i;
            end
        end
    endfunction

    function automatic void model_step();
        bit f;
        int wi, wc, wl, wv;
        if (!m_busy || last) begin
            model_arb(f, wi, wc, wl, wv);
            if (f) begin
                m_busy       = 1;
                m_grant_in   = wi;
                m_sel        = wi;
                m_vc_ptr[wl] = (wv + 1) % NV;
                m_in_ptr[wc] = (wi + 1) % NI;
            end else begin
                m_busy = 0;
            end
        end
    endfunction

    function automatic logic [NI-1:0] model_grant();
        logic [NI-1:0] g;
        g = '0;
        if (m_busy) g[m_grant_in] = 1'b1;
        return g;
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic set_identity();
        for (int c = 0; c < NC; c++) vmap[c] = 3'(c);
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        req    = '0;
        last   = 1'b0;
        set_identity();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        req    = '1;
        last   = 1'b0;
        set_identity();
        model_reset();
        #2;
        checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL reset_grant: got %b expected 0000", grant); end
        checks++; if (sel !== 2'd0) begin errors++; $display("FAIL reset_sel: got %0d expected 0", sel); end
        checks++; if (cts !== 1'b0) begin errors++; $display("FAIL reset_cts: got %b expected 0", cts); end
        repeat (2) @(posedge clk);
        #1;
        checks++; if (cts !== 1'b0) begin errors++; $display("FAIL reset_held_cts: got %b expected 0", cts); end
        resetn = 1'b1;
        req    = '0;
    endtask

    task automatic test_identity_rr();
        logic [NI-1:0] exp_g;
        do_reset();
        req = '1;
        for (int n = 0; n < 12; n++) begin
            tick();
            last  = 1'b0;
            exp_g = 4'(1 << ((n / 3) % NI));
            checks++; if (grant !== exp_g) begin errors++; $display("FAIL rr_grant pkt %0d: got %b expected %b", n, grant, exp_g); end
            checks++; if (sel !== 2'((n / 3) % NI)) begin errors++; $display("FAIL rr_sel pkt %0d: got %0d expected %0d", n, sel, (n / 3) % NI); end
            checks++; if (cts !== 1'b1) begin errors++; $display("FAIL rr_cts pkt %0d: got %b expected 1", n, cts); end
            for (int k = 0; k < 16; k++) begin
                tick();
                checks++; if (grant !== exp_g || cts !== 1'b1) begin errors++; $display("FAIL rr_hold pkt %0d: got %b/%b expected %b/1", n, grant, cts, exp_g); end
            end
            last = 1'b1;
        end
        tick();
        last = 1'b0;
        checks++; if (grant !== 4'b0001 || sel !== 2'd0) begin errors++; $display("FAIL rr_wrap: got %b/%0d expected 0001/0", grant, sel); end
    endtask

    task automatic test_priority_order();
        do_reset();
        req[0][0] = 1'b1;
        req[1][4] = 1'b1;
        req[3][1] = 1'b1;
        tick();
        checks++; if (grant !== 4'b0010 || sel !== 2'd1) begin errors++; $display("FAIL prio_first: got %b/%0d expected 0010/1", grant, sel); end
        req[1][4] = 1'b0;
        tick();
        checks++; if (grant !== 4'b0010) begin errors++; $display("FAIL prio_busy_hold: got %b expected 0010", grant); end
        last = 1'b1;
        tick();
        checks++; if (grant !== 4'b0001 || sel !== 2'd0) begin errors++; $display("FAIL prio_second: got %b/%0d expected 0001/0", grant, sel); end
        req[0][0] = 1'b0;
        tick();
        checks++; if (grant !== 4'b1000 || sel !== 2'd3 || cts !== 1'b1) begin errors++; $display("FAIL prio_third: got %b/%0d/%b expected 1000/3/1", grant, sel, cts); end
        req[3][1] = 1'b0;
        tick();
        last = 1'b0;
        checks++; if (grant !== 4'b0000 || cts !== 1'b0 || sel !== 2'd3) begin errors++; $display("FAIL prio_idle: got %b/%b/%0d expected 0000/0/3", grant, cts, sel); end
    endtask

    task automatic test_drop_hold();
        do_reset();
        req[1][0] = 1'b1;
        tick();
        checks++; if (grant !== 4'b0010 || cts !== 1'b1) begin errors++; $display("FAIL drop_grant: got %b/%b expected 0010/1", grant, cts); end
        req = '0;
        for (int k = 0; k < 5; k++) begin
            tick();
            checks++; if (grant !== 4'b0010 || cts !== 1'b1) begin errors++; $display("FAIL drop_hold: got %b/%b expected 0010/1", grant, cts); end
        end
        last = 1'b1;
        tick();
        checks++; if (grant !== 4'b0000 || cts !== 1'b0 || sel !== 2'd1) begin errors++; $display("FAIL drop_end: got %b/%b/%0d expected 0000/0/1", grant, cts, sel); end
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++; if (grant !== 4'b0000 || cts !== 1'b0 || sel !== 2'd1) begin errors++; $display("FAIL idle_last: got %b/%b/%0d expected 0000/0/1", grant, cts, sel); end
        end
        last = 1'b0;
    endtask

    task automatic test_disabled_class();
        do_reset();
        vmap[4]   = 3'd7;
        req[0][4] = 1'b1;
        req[2][4] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++; if (grant !== 4'b0000 || cts !== 1'b0) begin errors++; $display("FAIL disabled_7: got %b/%b expected 0000/0", grant, cts); end
        end
        vmap[4] = 3'd6;
        tick();
        checks++; if (grant !== 4'b0000 || cts !== 1'b0) begin errors++; $display("FAIL disabled_6: got %b/%b expected 0000/0", grant, cts); end
        vmap[4] = 3'd4;
        tick();
        checks++; if (grant !== 4'b0001 || cts !== 1'b1) begin errors++; $display("FAIL reenabled: got %b/%b expected 0001/1", grant, cts); end
    endtask

    task automatic test_remap();
        do_reset();
        vmap[0]   = 3'd5;
        req[2][0] = 1'b1;
        req[1][2] = 1'b1;
        tick();
        checks++; if (grant !== 4'b0100 || sel !== 2'd2) begin errors++; $display("FAIL remap_up: got %b/%0d expected 0100/2", grant, sel); end
        do_reset();
        vmap[0]   = 3'd5;
        req[2][0] = 1'b1;
        req[1][3] = 1'b1;
        tick();
        checks++; if (grant !== 4'b0010) begin errors++; $display("FAIL remap_vc0: got %b expected 0010", grant); end
        last = 1'b1;
        tick();
        last = 1'b0;
        checks++; if (grant !== 4'b0100) begin errors++; $display("FAIL remap_vc2: got %b expected 0100", grant); end
        do_reset();
        vmap[1]   = 3'd3;
        req[0][1] = 1'b1;
        req[3][3] = 1'b1;
        tick();
        checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL shared_low_src: got %b expected 0001", grant); end
        req[0][1] = 1'b0;
        last = 1'b1;
        tick();
        last = 1'b0;
        checks++; if (grant !== 4'b1000) begin errors++; $display("FAIL shared_next: got %b expected 1000", grant); end
    endtask

    task automatic test_reset_mid_packet();
        do_reset();
        for (int i = 0; i < NI; i++) req[i][3] = 1'b1;
        tick();
        last = 1'b1;
        tick();
        last = 1'b0;
        checks++; if (grant !== 4'b0010) begin errors++; $display("FAIL mid_pre: got %b expected 0010", grant); end
        #2;
        resetn = 1'b0;
        model_reset();
        #1;
        checks++; if (grant !== 4'b0000 || cts !== 1'b0 || sel !== 2'd0) begin errors++; $display("FAIL mid_reset: got %b/%b/%0d expected 0000/0/0", grant, cts, sel); end
        @(posedge clk);
        #1;
        resetn = 1'b1;
        tick();
        checks++; if (grant !== 4'b0001 || cts !== 1'b1) begin errors++; $display("FAIL mid_restart: got %b/%b expected 0001/1", grant, cts); end
    endtask

    task automatic test_random();
        logic [NI-1:0] eg;
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < NI; i++)
                for (int c = 0; c < NC; c++)
                    req[i][c] = ($urandom_range(0, 9) < 3);
            if ($urandom_range(0, 15) == 0) begin
                for (int c = 0; c < NC; c++)
                    vmap[c] = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'(c);
            end
            last = ($urandom_range(0, 3) == 0);
            tick();
            eg = model_grant();
            checks++;
            if (grant !== eg || sel !== 2'(m_sel) || cts !== m_busy) begin
                errors++;
                $display("FAIL random cycle %0d: got %b/%0d/%b expected %b/%0d/%b", n, grant, sel, cts, eg, m_sel, m_busy);
            end
        end
        last = 1'b0;
    endtask

    initial begin
        test_reset();
        test_identity_rr();
        test_priority_order();
        test_drop_hold();
        test_disabled_class();
        test_remap();
        test_reset_mid_packet();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
